vend_sequencer: RTL and testbench
=================================

# vend_sequencer

Sequencing controller for the coin-operated vending datapath. It decodes the two-bit coin code, keeps a saturating credit count in nickels, and runs the purchase sequence: it checks a buy request against the price, pulses the vend output once, then returns change one nickel per cycle. It sits between the coin acceptor and the dispense/change hardware, and owns the only credit register in the design.

## Interface
- PRICE, 4, item price in nickels (4 = 20c); must satisfy 1 ≤ PRICE ≤ CMAX
- CMAX, 15, credit ceiling in nickels
- CW, 4, credit width; must satisfy 2^CW > CMAX
- clk  in  1  system clock, all state on rising edge
- r  in  1  reset, synchronous, active-high
- x1, x0  in  1 each  coin code {x1,x0}: 00 none, 01 nickel (+1), 11 dime (+2), 10 invalid (ignored, no rej)
- buy  in  1  purchase request, level sampled each edge
- cancel  in  1  refund request, level sampled each edge
- z1  out  1  vend pulse, one cycle per purchase
- z0  out  1  change pulse, one cycle per nickel returned
- rej  out  1  coin rejected this cycle (physical return)
- busy  out  1  high outside IDLE
- credit  out  CW  current credit in nickels

## Operation
- States: IDLE, VEND, CHANGE. Reset state is IDLE.
- Reset values: credit=0, z1=0, z0=0, rej=0, busy=0.
- IDLE, evaluated at each edge in priority order:
  - cancel with credit>0: go to CHANGE; credit unchanged.
  - else buy with credit≥PRICE: go to VEND; credit ← credit−PRICE.
  - else: a valid coin adds its value to credit; stay in IDLE.
  - cancel with credit=0 and buy with credit<PRICE are ignored with no flag.
- The buy and cancel checks use the registered credit from before the edge. A coin that arrives in the same cycle as an accepted buy or cancel is rejected.
- Saturation: a coin is rejected if credit+value would exceed CMAX. A dime is never partially credited.
- VEND: lasts exactly one cycle. Next state is CHANGE if credit>0, otherwise IDLE.
- CHANGE: each edge decrements credit by 1. When credit goes from 1 to 0, the next state is IDLE. An entry credit of N produces exactly N z0 pulses.
- buy and cancel are ignored outside IDLE. Any valid coin outside IDLE is rejected and does not change credit.
- Credit arithmetic is done at width CW+1, then checked against CMAX. Credit never wraps.

## Timing
- Moore outputs, registered state:
  - z1 = (state==VEND)
  - z0 = (state==CHANGE)
  - busy = (state≠IDLE)
- rej is registered. It is high in the cycle after the edge that sampled the rejected coin.
- Latency from buy sampled at edge k (accepted):
  - z1 is high in cycle k..k+1.
  - The first z0 is in cycle k+1..k+2.
  - IDLE returns after 1+N cycles, where N is the change in nickels.
- credit is visible the cycle after each update.
- Reset asserted in any state takes effect at the next edge. It overrides all inputs. Outstanding change is forfeited (credit=0, no further z0).

## Structure
- Shared package `vend_pkg`:
  - state enum {IDLE, VEND, CHANGE}
  - coin code constants: COIN_NONE=2'b00, COIN_NICKEL=2'b01, COIN_DIME=2'b11, COIN_BAD=2'b10
  - nickel-value constants
- Sub-module `coin_decode`: combinational {x1,x0} → value[1:0] and valid. It is also reused by the coin-acceptor front end.
- Top level: the FSM, the credit register, the saturation check, and the rej register.

## Test plan
- Reset: assert r for 1 edge with coins applied → credit=0, z1=z0=rej=busy=0 on the next cycle.
- Dime, nickel, dime (credit 5), then buy → one z1 cycle, then one z0 cycle, credit 5→1→0, busy high for 2 cycles, then IDLE.
- Four nickels (credit 4), then buy → z1 for one cycle, no z0, IDLE on the next cycle, credit=0.
- Dime (credit 2), then buy → ignored, credit stays 2. Then cancel → two z0 pulses, credit 2→1→0.
- Saturation (PRICE=4, CMAX=15): seven dimes (credit 14), then a dime → rej=1, credit stays 14. Then a nickel → credit 15.
- Dime applied during VEND/CHANGE → rej=1, z0 count unchanged. Reset asserted mid-CHANGE at credit 3 → next cycle credit=0, z0=0, IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer and the coin-acceptor front end.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   localparam logic [1:0] COIN_NONE   = 2'b00;
   localparam logic [1:0] COIN_NICKEL = 2'b01;
   localparam logic [1:0] COIN_DIME   = 2'b11;
   localparam logic [1:0] COIN_BAD    = 2'b10;

   localparam logic [1:0] VAL_NONE    = 2'd0;
   localparam logic [1:0] VAL_NICKEL  = 2'd1;
   localparam logic [1:0] VAL_DIME    = 2'd2;

endpackage

// File: rtl/coin_decode.sv
// Combinational coin code decoder: {x1,x0} to nickel value and valid flag.
module coin_decode
   import vend_pkg::*;
(
   input  logic       x1,
   input  logic       x0,
   output logic [1:0] value,
   output logic       valid
);

   always_comb begin
      value = VAL_NONE;
      valid = 1'b0;
      case ({x1, x0})
         COIN_NICKEL: begin
            value = VAL_NICKEL;
            valid = 1'b1;
         end
         COIN_DIME: begin
            value = VAL_DIME;
            valid = 1'b1;
         end
         default: begin
            value = VAL_NONE;
            valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/vend_sequencer.sv
// Purchase sequencer: owns the credit register, checks buys against price,
// pulses vend once and returns change one nickel per cycle.
//
//   state  | meaning
//   IDLE   | accepting coins, buy and cancel
//   VEND   | one-cycle vend pulse on z1
//   CHANGE | one nickel returned per cycle on z0 until credit is zero
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE = 4,
   parameter int CMAX  = 15,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          r,
   input  logic          x1,
   input  logic          x0,
   input  logic          buy,
   input  logic          cancel,
   output logic          z1,
   output logic          z0,
   output logic          rej,
   output logic          busy,
   output logic [CW-1:0] credit
);

   localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
   localparam logic [CW:0]   CMAX_C  = (CW+1)'(CMAX);

   state_t      state;
   logic [1:0]  coin_val;
   logic        coin_vld;
   logic [CW:0] sum;
   logic        sat;

   coin_decode u_coin_decode (
      .x1    (x1),
      .x0    (x0),
      .value (coin_val),
      .valid (coin_vld)
   );

   // Extra bit keeps the sum from wrapping before the ceiling compare.
   assign sum = {1'b0, credit} + {{(CW-1){1'b0}}, coin_val};
   assign sat = (sum > CMAX_C);

   always_ff @(posedge clk) begin
      if (r) begin
         state  <= IDLE;
         credit <= '0;
         z1     <= 1'b0;
         z0     <= 1'b0;
         busy   <= 1'b0;
         rej    <= 1'b0;
      end else begin
         rej <= 1'b0;
         case (state)
            IDLE: begin
               if (cancel && credit != '0) begin
                  state <= CHANGE;
                  z0    <= 1'b1;
                  busy  <= 1'b1;
                  rej   <= coin_vld;
               end else if (buy && credit >= PRICE_C) begin
                  state  <= VEND;
                  credit <= credit - PRICE_C;
                  z1     <= 1'b1;
                  busy   <= 1'b1;
                  rej    <= coin_vld;
               end else if (coin_vld) begin
                  if (sat) rej <= 1'b1;
                  else     credit <= sum[CW-1:0];
               end
            end
            VEND: begin
               z1  <= 1'b0;
               rej <= coin_vld;
               if (credit != '0) begin
                  state <= CHANGE;
                  z0    <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            CHANGE: begin
               credit <= credit - 1'b1;
               rej    <= coin_vld;
               if (credit == {{(CW-1){1'b0}}, 1'b1}) begin
                  state <= IDLE;
                  z0    <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               z1    <= 1'b0;
               z0    <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: directed purchase scenarios followed by
// random coin/buy/cancel/reset traffic, checked against a plan-based model.
module tb_vend_sequencer;

   localparam int PRICE = 4;
   localparam int CMAX  = 15;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          r = 1'b1;
   logic          x1 = 1'b0;
   logic          x0 = 1'b0;
   logic          buy = 1'b0;
   logic          cancel = 1'b0;
   logic          z1, z0, rej, busy;
   logic [CW-1:0] credit;

   vend_sequencer #(.PRICE(PRICE), .CMAX(CMAX), .CW(CW)) dut (
      .clk    (clk),
      .r      (r),
      .x1     (x1),
      .x0     (x0),
      .buy    (buy),
      .cancel (cancel),
      .z1     (z1),
      .z0     (z0),
      .rej    (rej),
      .busy   (busy),
      .credit (credit)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit z1;
      bit z0;
      bit rej;
      bit busy;
      int credit;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model: credit in nickels plus a plan of upcoming busy cycles (1 = vend, 0 = change nickel).
   int m_credit = 0;
   bit plan[$];

   function automatic int coin_value(input logic [1:0] c);
      if (c == 2'b01) return 1;
      if (c == 2'b11) return 2;
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Drives one cycle of inputs and pushes the outputs expected after the sampling edge.
   task automatic cyc(input bit rr, input logic [1:0] coin, input bit b, input bit c);
      int   v;
      bit   rj;
      exp_t e;
      @(negedge clk);
      r = rr; {x1, x0} = coin; buy = b; cancel = c;
      v  = coin_value(coin);
      rj = 1'b0;
      if (rr) begin
         m_credit = 0;
         plan.delete();
      end else if (plan.size() > 0) begin
         if (plan[0] == 1'b0) m_credit--;
         void'(plan.pop_front());
         rj = (v != 0);
      end else if (c && m_credit > 0) begin
         for (int i = 0; i < m_credit; i++) plan.push_back(1'b0);
         rj = (v != 0);
      end else if (b && m_credit >= PRICE) begin
         m_credit -= PRICE;
         plan.push_back(1'b1);
         for (int i = 0; i < m_credit; i++) plan.push_back(1'b0);
         rj = (v != 0);
      end else if (v != 0) begin
         if (m_credit + v > CMAX) rj = 1'b1;
         else m_credit += v;
      end
      e.z1     = (plan.size() > 0) && plan[0];
      e.z0     = (plan.size() > 0) && !plan[0];
      e.busy   = (plan.size() > 0);
      e.rej    = rj;
      e.credit = m_credit;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("z1",     int'(z1),     int'(e.z1));
            check("z0",     int'(z0),     int'(e.z0));
            check("rej",    int'(rej),    int'(e.rej));
            check("busy",   int'(busy),   int'(e.busy));
            check("credit", int'(credit), e.credit);
         end
      end
   end

   initial begin : stimulus
      logic [1:0] coin;
      // reset with a coin applied
      cyc(1'b1, 2'b11, 1'b1, 1'b1);
      // dime, nickel, dime, buy -> vend + one nickel change
      cyc(1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b0, 2'b01, 1'b0, 1'b0);
      cyc(1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
      idle(3);
      // four nickels, buy -> exact price, no change
      repeat (4) cyc(1'b0, 2'b01, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
      idle(2);
      // underfunded buy ignored, then cancel refunds two nickels
      cyc(1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
      cyc(1'b0, 2'b00, 1'b0, 1'b1);
      idle(3);
      // invalid code and cancel at zero credit are ignored
      cyc(1'b0, 2'b10, 1'b0, 1'b1);
      // saturation: seven dimes, dime rejected, nickel reaches ceiling
      repeat (7) cyc(1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b0, 2'b01, 1'b0, 1'b0);
      cyc(1'b0, 2'b01, 1'b0, 1'b0);
      // buy with coin in same cycle: coin rejected; dimes during VEND/CHANGE rejected
      cyc(1'b0, 2'b11, 1'b1, 1'b0);
      cyc(1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b0, 2'b11, 1'b1, 1'b1);
      idle(12);
      // reach credit 7, buy -> CHANGE at 3, reset mid-change
      repeat (3) cyc(1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b0, 2'b01, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
      cyc(1'b0, 2'b00, 1'b0, 1'b0);
      cyc(1'b1, 2'b11, 1'b0, 1'b0);
      idle(2);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         coin = 2'($urandom_range(0, 3));
         cyc(($urandom_range(0, 199) == 0), coin,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
      end
      idle(2);
      @(posedge clk);
      #3;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
